f_comp_seq: RTL

- BLAKE2b compression-function (F) sequencer and datapath; it is the consumer side of the f_sched G-function schedule.
- Steps sub_ctr/rnd_ctr through an internal f_sched instance and uses the returned a/b/c/d/m0/m1 selects to read and write the 16-word working vector and 16-word message block.
- Runs one half-G mix per clock and produces the chained state h'.
- Sits between the block buffer/padding logic (upstream) and the digest output register (downstream).

---
 rtl/f_comp_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/f_comp_seq.sv
// BLAKE2b compression function F: sequences sub/rnd counters through f_sched and
// applies one half-G mix per clock to the 16-word working vector, producing h'.

module f_sched (
  input  logic [2:0] sub_ctr_i,
  input  logic [3:0] rnd_ctr_i,
  output logic [3:0] a_sel_o,
  output logic [3:0] b_sel_o,
  output logic [3:0] c_sel_o,
  output logic [3:0] d_sel_o,
  output logic [3:0] m0_sel_o,
  output logic [3:0] m1_sel_o
);
  logic [63:0] row;
  logic [1:0]  j;

  // Sigma permutation rows; element k sits in nibble k.
  always_comb begin
    row = '0;
    case (rnd_ctr_i)
      4'd0, 4'd10: row = 64'hfedcba9876543210;
      4'd1, 4'd11: row = 64'h357b20c16df984ae;
      4'd2:        row = 64'h491763eadf250c8b;
      4'd3:        row = 64'h8f04a562ebcd1397;
      4'd4:        row = 64'hd386cb1efa427509;
      4'd5:        row = 64'h91ef57d438b0a6c2;
      4'd6:        row = 64'hb8293670a4def15c;
      4'd7:        row = 64'ha2684f05931ce7bd;
      4'd8:        row = 64'h5a417d2c803b9ef6;
      4'd9:        row = 64'h0dc3e9bf5167482a;
      default:     row = 'x;
    endcase
  end

  // sub 0..3 are the columns, sub 4..7 the diagonals.
  always_comb begin
    j       = sub_ctr_i[1:0];
    a_sel_o = {2'b00, j};
    b_sel_o = {2'b01, j};
    c_sel_o = {2'b10, j};
    d_sel_o = {2'b11, j};
    if (sub_ctr_i[2]) begin
      b_sel_o = {2'b01, 2'(j + 2'd1)};
      c_sel_o = {2'b10, 2'(j + 2'd2)};
      d_sel_o = {2'b11, 2'(j + 2'd3)};
    end
    m0_sel_o = row[{sub_ctr_i, 1'b0, 2'b00} +: 4];
    m1_sel_o = row[{sub_ctr_i, 1'b1, 2'b00} +: 4];
  end
endmodule

module f_comp_seq #(
  parameter int unsigned ROUNDS = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [511:0]  h_in,
  input  logic [1023:0] m_in,
  input  logic [127:0]  t_in,
  input  logic          last_in,
  output logic          busy,
  output logic          done,
  output logic [511:0]  h_out
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [63:0] IV [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [2:0]   sub_ctr_q, sub_ctr_d;
  logic [3:0]   rnd_ctr_q, rnd_ctr_d;
  logic         ph_q, ph_d;
  logic [63:0]  v_q [16];
  logic [63:0]  v_d [16];
  logic [63:0]  m_q [16];
  logic [63:0]  m_d [16];
  logic [63:0]  h_q [8];
  logic [63:0]  h_d [8];
  logic [511:0] h_out_q, h_out_d;
  logic         done_q, done_d;

  logic [3:0]   a_sel, b_sel, c_sel, d_sel, m0_sel, m1_sel;
  logic [63:0]  mw, a1, dx, dr, c1, bx, br;

  f_sched u_sched (
    .sub_ctr_i (sub_ctr_q),
    .rnd_ctr_i (rnd_ctr_q),
    .a_sel_o   (a_sel),
    .b_sel_o   (b_sel),
    .c_sel_o   (c_sel),
    .d_sel_o   (d_sel),
    .m0_sel_o  (m0_sel),
    .m1_sel_o  (m1_sel)
  );

  // Half-G: phase picks message word and rotation amounts.
  always_comb begin
    mw = ph_q ? m_q[m1_sel] : m_q[m0_sel];
    a1 = v_q[a_sel] + v_q[b_sel] + mw;
    dx = v_q[d_sel] ^ a1;
    dr = ph_q ? {dx[15:0], dx[63:16]} : {dx[31:0], dx[63:32]};
    c1 = v_q[c_sel] + dr;
    bx = v_q[b_sel] ^ c1;
    br = ph_q ? {bx[62:0], bx[63]} : {bx[23:0], bx[63:24]};
  end

  always_comb begin
    state_d   = state_q;
    sub_ctr_d = sub_ctr_q;
    rnd_ctr_d = rnd_ctr_q;
    ph_d      = ph_q;
    v_d       = v_q;
    m_d       = m_q;
    h_d       = h_q;
    h_out_d   = h_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_in[64*i +: 64];
          v_d[i] = h_in[64*i +: 64];
        end
        for (int i = 0; i < 16; i++) m_d[i] = m_in[64*i +: 64];
        v_d[8]    = IV[0];
        v_d[9]    = IV[1];
        v_d[10]   = IV[2];
        v_d[11]   = IV[3];
        v_d[12]   = IV[4] ^ t_in[63:0];
        v_d[13]   = IV[5] ^ t_in[127:64];
        v_d[14]   = IV[6] ^ {64{last_in}};
        v_d[15]   = IV[7];
        sub_ctr_d = '0;
        rnd_ctr_d = '0;
        ph_d      = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        v_d[a_sel] = a1;
        v_d[b_sel] = br;
        v_d[c_sel] = c1;
        v_d[d_sel] = dr;
        ph_d       = ~ph_q;
        if (ph_q) begin
          sub_ctr_d = sub_ctr_q + 3'd1;
          if (sub_ctr_q == 3'd7) begin
            if (rnd_ctr_q == LAST_RND) begin
              rnd_ctr_d = '0;
              state_d   = FIN;
            end else begin
              rnd_ctr_d = rnd_ctr_q + 4'd1;
            end
          end
        end
      end
      FIN: begin
        for (int i = 0; i < 8; i++) h_out_d[64*i +: 64] = h_q[i] ^ v_q[i] ^ v_q[i+8];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sub_ctr_q <= '0;
      rnd_ctr_q <= '0;
      ph_q      <= 1'b0;
      h_out_q   <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= '0;
        m_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) h_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sub_ctr_q <= sub_ctr_d;
      rnd_ctr_q <= rnd_ctr_d;
      ph_q      <= ph_d;
      h_out_q   <= h_out_d;
      done_q    <= done_d;
      v_q       <= v_d;
      m_q       <= m_d;
      h_q       <= h_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign h_out = h_out_q;
endmodule
